bsg_mux_segmented_arb: RTL and testbench
========================================

# bsg_mux_segmented_arb

Two-requester, packet-aware round-robin arbiter that shares one segmented merge datapath and one registered output stream. Each cycle it picks one input beat and merges it into the output register segment by segment. Segments whose enable is 1 take the new data. Segments whose enable is 0 keep the previously emitted value. It sits in front of any single-consumer sink that two producers must share, and it is the control layer for the segmented 2:1 mux datapath.

## Interface
Parameters:
- width_p, 16, total data width; must be a multiple of segments_p.
- segments_p, 4, number of independently selected segments; segment width = width_p/segments_p.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- v0_i  in  1  requester 0 beat valid.
- data0_i  in  width_p  requester 0 data.
- seg_en0_i  in  segments_p  requester 0 per-segment write enable; bit k covers data bits [k*seg_w +: seg_w].
- last0_i  in  1  requester 0 final beat of packet.
- yumi0_o  out  1  requester 0 beat consumed this cycle.
- v1_i, data1_i, seg_en1_i, last1_i, yumi1_o  same as requester 0, for requester 1.
- v_o  out  1  output register holds a valid beat.
- data_o  out  width_p  merged output data.
- last_o  out  1  last flag of held beat.
- sel_o  out  1  source index of held beat.
- ready_i  in  1  consumer accepts the held beat when v_o & ready_i.

## Operation
- Output register: a one-entry pipeline stage. space = ~v_o | ready_i.
- FSM states:
  - IDLE: no packet in progress.
  - LOCK0: requester 0 holds the grant.
  - LOCK1: requester 1 holds the grant.
- Grant in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester not recorded in last_grant_r wins (round-robin).
- Grant in LOCKn: only requester n is eligible; the other requester's valid is ignored.
- Transfer: occurs when the winner is valid and space=1. That cycle:
  - yumiN_o=1 for the winner only; the loser's yumi stays 0.
  - Output register loads; v_o=1 the next cycle.
- Merge on transfer, per segment k:
  - data_o[k] ← winner data[k] if seg_en[k]=1, else data_o[k] unchanged. This applies even if v_o was 0.
  - All-zero seg_en is legal: v_o/last_o/sel_o update and data_o is unchanged.
- State transitions on transfer:
  - last=0 → enter or stay in LOCKwinner.
  - last=1 → go to IDLE and set last_grant_r ← winner.
- Dequeue: v_o & ready_i with no same-cycle transfer → v_o=0 next cycle. data_o, last_o and sel_o hold their values.
- Simultaneous dequeue and transfer → v_o stays 1 and the new beat loads (full throughput).
- Combinational paths: yumiN_o depends on v0_i, v1_i, ready_i and state. No path runs from any input to v_o, data_o, last_o or sel_o.

## Timing
- Latency: input beat to v_o is 1 cycle. Sustained throughput is 1 beat/cycle while ready_i=1.
- Reset (asynchronous, including mid-packet) forces:
  - v_o=0, data_o=0, last_o=0, sel_o=0.
  - State=IDLE, last_grant_r=1, so requester 0 wins the first tie.
- A packet partially transferred at reset is abandoned; the bench must not expect completion.
- Backpressure: ready_i=0 with v_o=1 → no yumi asserted, output held stable.
- Lock persists across idle gaps: in LOCKn with vn_i=0, the other requester still receives no grant.

## Configuration
- BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN defined:
  - LOCK0/LOCK1 states exist; packets are atomic as described.
- Not defined:
  - FSM removed; every beat is arbitrated as in IDLE.
  - last_grant_r updates on every transfer.
  - lastN_i passes through to last_o only.
  - Beats from the two requesters may interleave.

## Test plan
- Reset, then v0_i=1, data0_i=16'hABCD, seg_en0_i=4'hF, last0_i=1, ready_i=1 → yumi0_o=1 same cycle. Next cycle: v_o=1, data_o=16'hABCD, sel_o=0, last_o=1.
- Both requesters continuously valid, all last=1, ready_i=1 → yumi alternates 0,1,0,1… starting with 0 after reset; sel_o follows one cycle later.
- Requester 1 sends a 3-beat packet (last on beat 3) while requester 0 is valid throughout → three consecutive sel_o=1 beats, then requester 0 is granted. Without the macro, the beats interleave.
- Output holds 16'h1234. Next beat 16'hFFFF with seg_en=4'b0101 → data_o=16'h1F3F.
- ready_i=0 for 4 cycles with both inputs valid → no yumi, data_o stable. ready_i returns to 1 → one transfer per cycle resumes with no lost beat.
- Assert reset_i mid-packet in LOCK0 → v_o=0 and data_o=0 immediately. After release, a tie grants requester 0 from IDLE.

Source files
------------

// File: rtl/bsg_mux_segmented_arb.sv
// Two-requester round-robin arbiter feeding a segmented-merge output register.
// Define BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN to hold the grant for a whole packet.
module bsg_mux_segmented_arb #(
   parameter int width_p    = 16,
   parameter int segments_p = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  v0_i,
   input  logic [width_p-1:0]    data0_i,
   input  logic [segments_p-1:0] seg_en0_i,
   input  logic                  last0_i,
   output logic                  yumi0_o,
   input  logic                  v1_i,
   input  logic [width_p-1:0]    data1_i,
   input  logic [segments_p-1:0] seg_en1_i,
   input  logic                  last1_i,
   output logic                  yumi1_o,
   output logic                  v_o,
   output logic [width_p-1:0]    data_o,
   output logic                  last_o,
   output logic                  sel_o,
   input  logic                  ready_i
);

   localparam int seg_w_lp = width_p / segments_p;

`ifdef BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN
   localparam logic [1:0] idle_s  = 2'd0;
   localparam logic [1:0] lock0_s = 2'd1;
   localparam logic [1:0] lock1_s = 2'd2;

   logic [1:0] state_r;
`endif

   logic                  last_grant_r;
   logic                  space;
   logic                  arb_win;
   logic                  win;
   logic                  win_v;
   logic                  xfer;
   logic [width_p-1:0]    win_data;
   logic [segments_p-1:0] win_seg_en;
   logic                  win_last;

   assign space = ~v_o | ready_i;

   // Requester 1 wins alone, or on a tie when requester 0 was granted last.
   assign arb_win = v1_i & (~v0_i | ~last_grant_r);

   always_comb begin
      win = arb_win;
`ifdef BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN
      case (state_r)
         lock0_s: win = 1'b0;
         lock1_s: win = 1'b1;
         default: win = arb_win;
      endcase
`endif
   end

   assign win_v      = win ? v1_i      : v0_i;
   assign win_data   = win ? data1_i   : data0_i;
   assign win_seg_en = win ? seg_en1_i : seg_en0_i;
   assign win_last   = win ? last1_i   : last0_i;

   assign xfer    = win_v & space;
   assign yumi0_o = xfer & ~win;
   assign yumi1_o = xfer &  win;

`ifdef BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r      <= idle_s;
         last_grant_r <= 1'b1;
      end else if (xfer) begin
         if (win_last) begin
            state_r      <= idle_s;
            last_grant_r <= win;
         end else begin
            state_r <= win ? lock1_s : lock0_s;
         end
      end
   end
`else
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         last_grant_r <= 1'b1;
      else if (xfer)
         last_grant_r <= win;
   end
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_o    <= 1'b0;
         last_o <= 1'b0;
         sel_o  <= 1'b0;
      end else if (xfer) begin
         v_o    <= 1'b1;
         last_o <= win_last;
         sel_o  <= win;
      end else if (ready_i) begin
         v_o <= 1'b0;
      end
   end

   // Disabled segments keep the previously emitted bits, even across an empty slot.
   for (genvar k = 0; k < segments_p; k++) begin : g_seg
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i)
            data_o[k*seg_w_lp +: seg_w_lp] <= '0;
         else if (xfer && win_seg_en[k])
            data_o[k*seg_w_lp +: seg_w_lp] <= win_data[k*seg_w_lp +: seg_w_lp];
      end
   end

endmodule

// File: tb/tb_bsg_mux_segmented_arb.sv
// Scoreboard bench for bsg_mux_segmented_arb: driver pushes hand-computed beats,
// monitor pops one per transfer; packet expectations follow BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN.
module tb_bsg_mux_segmented_arb;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        v0_i = 1'b0, v1_i = 1'b0;
   logic [15:0] data0_i = '0, data1_i = '0;
   logic [3:0]  seg_en0_i = '0, seg_en1_i = '0;
   logic        last0_i = 1'b0, last1_i = 1'b0;
   logic        yumi0_o, yumi1_o;
   logic        v_o;
   logic [15:0] data_o;
   logic        last_o, sel_o;
   logic        ready_i = 1'b0;

   int checks = 0;
   int passes = 0;

   logic [17:0] exp_q[$];   // {data, last, sel}

   bsg_mux_segmented_arb #(.width_p(16), .segments_p(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .v0_i(v0_i), .data0_i(data0_i), .seg_en0_i(seg_en0_i), .last0_i(last0_i), .yumi0_o(yumi0_o),
      .v1_i(v1_i), .data1_i(data1_i), .seg_en1_i(seg_en1_i), .last1_i(last1_i), .yumi1_o(yumi1_o),
      .v_o(v_o), .data_o(data_o), .last_o(last_o), .sel_o(sel_o), .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
   endtask

   // One cycle of stimulus; ed is the hand-computed merged output for a granted beat.
   task automatic cyc(input logic a_v0, input logic [15:0] a_d0, input logic [3:0] a_e0, input logic a_l0,
                      input logic a_v1, input logic [15:0] a_d1, input logic [3:0] a_e1, input logic a_l1,
                      input logic a_rdy, input logic ey0, input logic ey1, input logic [15:0] ed);
      @(posedge clk_i); #1;
      v0_i = a_v0; data0_i = a_d0; seg_en0_i = a_e0; last0_i = a_l0;
      v1_i = a_v1; data1_i = a_d1; seg_en1_i = a_e1; last1_i = a_l1;
      ready_i = a_rdy;
      #3;
      chk("yumi0", {17'b0, yumi0_o}, {17'b0, ey0});
      chk("yumi1", {17'b0, yumi1_o}, {17'b0, ey1});
      if (ey0) exp_q.push_back({ed, a_l0, 1'b0});
      if (ey1) exp_q.push_back({ed, a_l1, 1'b1});
   endtask

   // Monitor: a beat granted before a rising edge is presented just after it.
   initial begin
      logic got;
      logic [17:0] e;
      forever begin
         @(negedge clk_i);
         got = yumi0_o | yumi1_o;
         @(posedge clk_i); #2;
         if (got) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {data_o, last_o, sel_o}, 18'h0);
               checks++;
            end else begin
               e = exp_q.pop_front();
               chk("beat_v", {17'b0, v_o}, 18'h1);
               chk("beat", {data_o, last_o, sel_o}, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("reset_out", {data_o, last_o, sel_o}, 18'h0);
      chk("reset_v", {17'b0, v_o}, 18'h0);
      @(posedge clk_i); #1 reset_i = 1'b0;

      // Single beat, full enable
      cyc(1, 16'hABCD, 4'hF, 1, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'hABCD);
      cyc(0, 16'h0, 4'h0, 0, 0, 16'h0, 4'h0, 0, 1, 0, 0, 16'h0);

      // Segment merge: 1234 then FFFF with 0101
      cyc(1, 16'h1234, 4'hF, 1, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'h1234);
      cyc(0, 16'h0, 4'h0, 0, 1, 16'hFFFF, 4'b0101, 1, 1, 0, 1, 16'h1F3F);

      // All-zero enables: flags move, data stays
      cyc(1, 16'h0000, 4'h0, 0, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'h1F3F);
      cyc(1, 16'hAAAA, 4'h0, 1, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'h1F3F);

      // Backpressure for 4 cycles with both valid
      for (int i = 0; i < 4; i++) begin
         cyc(1, 16'h1111, 4'hF, 1, 1, 16'h2222, 4'hF, 1, 0, 0, 0, 16'h0);
         chk("stall_data", {2'b0, data_o}, {2'b0, 16'h1F3F});
         chk("stall_v", {17'b0, v_o}, 18'h1);
      end
      cyc(1, 16'h1111, 4'hF, 1, 1, 16'h2222, 4'hF, 1, 1, 0, 1, 16'h2222);
      cyc(1, 16'h1111, 4'hF, 1, 1, 16'h2222, 4'hF, 1, 1, 1, 0, 16'h1111);
      cyc(1, 16'h1111, 4'hF, 1, 1, 16'h2222, 4'hF, 1, 1, 0, 1, 16'h2222);

      // Requester 1 sends a 3-beat packet while requester 0 competes
`ifdef BSG_MUX_SEGMENTED_ARB_PKT_LOCK_EN
      cyc(0, 16'h0A0A, 4'hF, 1, 1, 16'hB001, 4'hF, 0, 1, 0, 1, 16'hB001);
      cyc(1, 16'h0A0A, 4'hF, 1, 0, 16'h0, 4'h0, 0, 1, 0, 0, 16'h0);
      cyc(1, 16'h0A0A, 4'hF, 1, 1, 16'hB002, 4'hF, 0, 1, 0, 1, 16'hB002);
      cyc(1, 16'h0A0A, 4'hF, 1, 1, 16'hB003, 4'hF, 1, 1, 0, 1, 16'hB003);
      cyc(1, 16'h0A0A, 4'hF, 1, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'h0A0A);
`else
      cyc(0, 16'h0A0A, 4'hF, 1, 1, 16'hB001, 4'hF, 0, 1, 0, 1, 16'hB001);
      cyc(1, 16'h0A0A, 4'hF, 1, 1, 16'hB002, 4'hF, 0, 1, 1, 0, 16'h0A0A);
      cyc(1, 16'h0A0A, 4'hF, 1, 1, 16'hB002, 4'hF, 0, 1, 0, 1, 16'hB002);
      cyc(1, 16'h0A0A, 4'hF, 1, 1, 16'hB003, 4'hF, 1, 1, 1, 0, 16'h0A0A);
      cyc(0, 16'h0A0A, 4'hF, 1, 1, 16'hB003, 4'hF, 1, 1, 0, 1, 16'hB003);
`endif

      // Reset in the middle of a requester-0 packet
      cyc(1, 16'hC0DE, 4'hF, 0, 0, 16'h0, 4'h0, 0, 1, 1, 0, 16'hC0DE);
      @(posedge clk_i); #3;
      reset_i = 1'b1; v0_i = 1'b0; v1_i = 1'b0;
      #1;
      chk("midreset_out", {data_o, last_o, sel_o}, 18'h0);
      chk("midreset_v", {17'b0, v_o}, 18'h0);
      @(posedge clk_i); #1 reset_i = 1'b0;

      // Tie after reset starts with requester 0 and alternates
      for (int i = 0; i < 3; i++) begin
         cyc(1, 16'h5550, 4'hF, 1, 1, 16'h6661, 4'hF, 1, 1, 1, 0, 16'h5550);
         cyc(1, 16'h5550, 4'hF, 1, 1, 16'h6661, 4'hF, 1, 1, 0, 1, 16'h6661);
      end

      // Dequeue without new beat: valid drops, payload holds
      cyc(0, 16'h0, 4'h0, 0, 0, 16'h0, 4'h0, 0, 1, 0, 0, 16'h0);
      @(posedge clk_i); #3;
      chk("dequeue_v", {17'b0, v_o}, 18'h0);
      chk("dequeue_hold", {data_o, last_o, sel_o}, {16'h6661, 1'b1, 1'b1});

      @(posedge clk_i); #3;
      chk("queue_empty", exp_q.size(), 18'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
